// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared widths and FSM state encoding for the Gray monitor
// Purpose: default code/counter widths and the monitor FSM state type.
// Ports: none (package).
package gray_pkg;

    localparam int GRAY_WIDTH = 3;
    localparam int WRAP_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary converter
// Purpose: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
// Ports:
//   gray_i  in   WIDTH  Gray code
//   bin_o   out  WIDTH  binary equivalent
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^(gray_i >> i);
    end

endmodule

// File: rtl/gray_monitor.sv
// rtl/gray_monitor.sv - Gray counter consumer: conversion, step checking, wrap counting
// Purpose: converts each valid Gray sample to registered binary, checks that
//   consecutive samples are legal single increments with a consistent overflow
//   flag, counts legal max->0 wraps (saturating) and flags errors sticky.
// Ports:
//   Clk, Reset (sync, active-high), Clear (sync clear of errors/wraps/FSM)
//   Valid, Gray[WIDTH], Ovf_in          sample inputs
//   Bin[WIDTH], Bin_valid               registered conversion result + pulse
//   Step_err, Err_sticky                error pulse and its sticky copy
//   Wrap_cnt[WRAP_W], State[2]          wrap counter and FSM state for debug
module gray_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH  = GRAY_WIDTH,
    parameter int WRAP_W = WRAP_WIDTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  Gray,
    input  logic              Ovf_in,
    output logic [WIDTH-1:0]  Bin,
    output logic              Bin_valid,
    output logic              Step_err,
    output logic              Err_sticky,
    output logic [WRAP_W-1:0] Wrap_cnt,
    output logic [1:0]        State
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic                bin_valid_q, bin_valid_d;
    logic                step_err_q, step_err_d;
    logic                err_sticky_q, err_sticky_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;

    logic [WIDTH-1:0]    n_bin;
    logic [WIDTH-1:0]    p_inc;
    logic                p_max;
    logic                step_bad;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray_i (Gray),
        .bin_o  (n_bin)
    );

    // p+1 is only compared when prev is not at max; the max->0 case is the
    // explicit wrap branch, so the modulo rollover of p_inc is never relied on.
    assign p_inc = prev_q + WIDTH'(1);
    assign p_max = (prev_q == '1);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        bin_d        = bin_q;
        bin_valid_d  = 1'b0;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        wrap_d       = wrap_q;
        step_bad     = 1'b0;

        if (Valid) begin
            bin_d       = n_bin;
            bin_valid_d = 1'b1;
            prev_d      = n_bin;
        end

        case (state_q)
            ST_IDLE: begin
                if (Valid) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (Valid && (n_bin != prev_q)) begin
                    if (!p_max && (n_bin == p_inc)) begin
                        // Upstream overflow must agree with whether we have seen a wrap.
                        step_bad = (Ovf_in != (wrap_q != '0));
                    end else if (p_max && (n_bin == '0)) begin
                        if (!Ovf_in) begin
                            step_bad = 1'b1;
                        end else if (wrap_q != '1) begin
                            wrap_d = wrap_q + WRAP_W'(1);
                        end
                    end else begin
                        step_bad = 1'b1;
                    end
                end
                if (step_bad) begin
                    step_err_d   = 1'b1;
                    err_sticky_d = 1'b1;
                    state_d      = ST_ERROR;
                end
            end
            ST_ERROR: begin
                // Terminal until Clear/Reset; conversion continues above.
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear discards any same-cycle sample but keeps the last Bin.
        if (Clear) begin
            state_d      = ST_IDLE;
            prev_d       = '0;
            bin_d        = bin_q;
            bin_valid_d  = 1'b0;
            step_err_d   = 1'b0;
            err_sticky_d = 1'b0;
            wrap_d       = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            bin_q        <= '0;
            bin_valid_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_q       <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            bin_q        <= bin_d;
            bin_valid_q  <= bin_valid_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_q       <= wrap_d;
        end
    end

    assign Bin        = bin_q;
    assign Bin_valid  = bin_valid_q;
    assign Step_err   = step_err_q;
    assign Err_sticky = err_sticky_q;
    assign Wrap_cnt   = wrap_q;
    assign State      = state_q;

endmodule

// File: tb/tb_gray_monitor.sv
// tb/tb_gray_monitor.sv - directed self-checking bench for gray_monitor
module tb_gray_monitor;

    logic       clk = 1'b0;
    logic       reset, clear, valid, ovf;
    logic [2:0] gray;

    logic [2:0] bin, bin2;
    logic       bin_valid, step_err, err_sticky;
    logic       bin_valid2, step_err2, err_sticky2;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;
    logic [1:0] state, state2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gray_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
        .Clk(clk), .Reset(reset), .Clear(clear), .Valid(valid), .Gray(gray), .Ovf_in(ovf),
        .Bin(bin), .Bin_valid(bin_valid), .Step_err(step_err), .Err_sticky(err_sticky),
        .Wrap_cnt(wrap_cnt), .State(state)
    );

    gray_monitor #(.WIDTH(3), .WRAP_W(2)) dut_w2 (
        .Clk(clk), .Reset(reset), .Clear(clear), .Valid(valid), .Gray(gray), .Ovf_in(ovf),
        .Bin(bin2), .Bin_valid(bin_valid2), .Step_err(step_err2), .Err_sticky(err_sticky2),
        .Wrap_cnt(wrap_cnt2), .State(state2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
    task automatic apply(input logic r, input logic c, input logic v,
                         input logic [2:0] g, input logic o);
        reset = r;
        clear = c;
        valid = v;
        gray  = g;
        ovf   = o;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] seq1 [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    initial begin
        int wraps;
        reset = 1'b1; clear = 1'b0; valid = 1'b0; gray = 3'b000; ovf = 1'b0;
        @(posedge clk); #1;

        // Reset state
        apply(1, 0, 0, 3'b101, 1);
        check_eq("rst_bin", bin, 0);
        check_eq("rst_bvalid", bin_valid, 0);
        check_eq("rst_steperr", step_err, 0);
        check_eq("rst_sticky", err_sticky, 0);
        check_eq("rst_wrap", wrap_cnt, 0);
        check_eq("rst_state", state, 0);

        // 1: full legal count 0..7
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 1, seq1[i], 0);
            check_eq("t1_bin", bin, i);
            check_eq("t1_bvalid", bin_valid, 1);
            check_eq("t1_steperr", step_err, 0);
        end
        check_eq("t1_state", state, 1);
        apply(0, 0, 0, 3'b000, 0);
        check_eq("idle_bvalid", bin_valid, 0);
        check_eq("idle_bin_hold", bin, 7);

        // 2: legal wrap with overflow, then step with overflow set
        apply(0, 0, 1, 3'b000, 1);
        check_eq("t2_bin", bin, 0);
        check_eq("t2_steperr", step_err, 0);
        check_eq("t2_wrap", wrap_cnt, 1);
        apply(0, 0, 1, 3'b001, 1);
        check_eq("t2_step_bin", bin, 1);
        check_eq("t2_step_err", step_err, 0);
        check_eq("t2_step_wrap", wrap_cnt, 1);

        // 3: illegal jump 2 -> 4, then ERROR keeps converting
        apply(0, 0, 1, 3'b011, 1);
        check_eq("t3_bin2", bin, 2);
        check_eq("t3_ok_err", step_err, 0);
        apply(0, 0, 1, 3'b110, 1);
        check_eq("t3_jump_err", step_err, 1);
        check_eq("t3_sticky", err_sticky, 1);
        check_eq("t3_state", state, 2);
        check_eq("t3_jump_bin", bin, 4);
        apply(0, 0, 1, 3'b111, 1);
        check_eq("t3_err_bin", bin, 5);
        check_eq("t3_err_bvalid", bin_valid, 1);
        check_eq("t3_err_pulse", step_err, 0);
        check_eq("t3_err_sticky", err_sticky, 1);
        check_eq("t3_err_wrap", wrap_cnt, 1);

        // 5a: Clear together with Valid
        apply(0, 1, 1, 3'b001, 0);
        check_eq("t5_sticky", err_sticky, 0);
        check_eq("t5_wrap", wrap_cnt, 0);
        check_eq("t5_state", state, 0);
        check_eq("t5_bvalid", bin_valid, 0);
        check_eq("t5_bin_hold", bin, 5);

        // 4: wrap 7->0 without overflow
        apply(0, 0, 1, 3'b100, 0);
        check_eq("t4_start_bin", bin, 7);
        check_eq("t4_start_state", state, 1);
        apply(0, 0, 1, 3'b000, 0);
        check_eq("t4_err", step_err, 1);
        check_eq("t4_sticky", err_sticky, 1);
        check_eq("t4_wrap", wrap_cnt, 0);
        check_eq("t4_state", state, 2);

        // Legal step with overflow set but no wrap seen
        apply(0, 1, 0, 3'b000, 0);
        apply(0, 0, 1, 3'b000, 0);
        apply(0, 0, 1, 3'b001, 1);
        check_eq("ovf_mis_err", step_err, 1);
        check_eq("ovf_mis_state", state, 2);

        // 5b: Reset mid-count
        apply(0, 1, 0, 3'b000, 0);
        apply(0, 0, 1, 3'b000, 0);
        apply(0, 0, 1, 3'b001, 0);
        apply(0, 0, 1, 3'b011, 0);
        check_eq("t5b_pre_bin", bin, 2);
        apply(1, 0, 1, 3'b010, 1);
        check_eq("t5b_bin", bin, 0);
        check_eq("t5b_bvalid", bin_valid, 0);
        check_eq("t5b_steperr", step_err, 0);
        check_eq("t5b_sticky", err_sticky, 0);
        check_eq("t5b_wrap", wrap_cnt, 0);
        check_eq("t5b_state", state, 0);

        // 6: five legal wraps; the 2-bit counter saturates at 3
        apply(0, 0, 1, 3'b000, 0);
        wraps = 0;
        for (int w = 0; w < 5; w++) begin
            for (int b = 1; b < 8; b++) begin
                logic [2:0] bb;
                bb = 3'(b);
                apply(0, 0, 1, bb ^ (bb >> 1), (wraps > 0));
                check_eq("t6_step_err", step_err, 0);
                check_eq("t6_step_err_w2", step_err2, 0);
            end
            apply(0, 0, 1, 3'b000, 1);
            wraps++;
            check_eq("t6_wrap", wrap_cnt, wraps);
            check_eq("t6_wrap_w2", wrap_cnt2, (wraps > 3) ? 3 : wraps);
            check_eq("t6_wrap_err_w2", step_err2, 0);
        end
        check_eq("t6_sticky_w2", err_sticky2, 0);
        check_eq("t6_state_w2", state2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
